// File: rtl/sub_seq.sv
// Nibble-serial multi-word subtractor: one 4-bit subtract slice, NIB cycles per operation, LS nibble first.
// Optional zero flag built only when SUB_SEQ_ZERO_FLAG_EN is defined.
module sub_seq #(
    parameter int NIB = 4
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [4*NIB-1:0]  s,
    output logic              borrow,
    output logic              zero
);
    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [KW-1:0]   k_r;
    logic            bin_r;

    logic [KW+1:0]   sh_s;
    logic [3:0]      a_nib_s;
    logic [3:0]      b_nib_s;
    logic [4:0]      d_s;
    logic [W-1:0]    s_next_s;
    logic            last_s;

    // 4-bit subtract slice in 5-bit arithmetic; bit 4 is the outgoing borrow
    function automatic logic [4:0] sub_nib(input logic [3:0] x, input logic [3:0] y, input logic bi);
        sub_nib = {1'b0, x} - {1'b0, y} - {4'b0000, bi};
    endfunction

    // Select current nibble, subtract, and splice the result into s
    always_comb begin
        sh_s     = {k_r, 2'b00};
        a_nib_s  = 4'(a_r >> sh_s);
        b_nib_s  = 4'(b_r >> sh_s);
        d_s      = sub_nib(a_nib_s, b_nib_s, bin_r);
        s_next_s = (s & ~(W'(4'hF) << sh_s)) | (W'(d_s[3:0]) << sh_s);
        last_s   = (k_r == KW'(NIB - 1));
    end

`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic zero_r;
    assign zero = zero_r;
`else
    assign zero = 1'b0;
`endif

    // Control FSM with registered outputs and datapath state
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            k_r     <= '0;
            bin_r   <= 1'b0;
            s       <= '0;
            borrow  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SUB_SEQ_ZERO_FLAG_EN
            zero_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        k_r     <= '0;
                        bin_r   <= 1'b0;
                        s       <= '0;
                        borrow  <= 1'b0;
                        busy    <= 1'b1;
`ifdef SUB_SEQ_ZERO_FLAG_EN
                        zero_r  <= 1'b0;
`endif
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    s     <= s_next_s;
                    bin_r <= d_s[4];
                    if (last_s) begin
                        borrow  <= d_s[4];
                        done    <= 1'b1;
`ifdef SUB_SEQ_ZERO_FLAG_EN
                        zero_r  <= (s_next_s == '0);
`endif
                        state_r <= ST_DONE;
                    end else begin
                        // index stays at NIB-1 on the final nibble; accept clears it
                        k_r     <= k_r + KW'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_seq.sv
// Directed bench for sub_seq: NIB=4 vector table plus corner sequences, and an exhaustive NIB=1 instance.
module tb_sub_seq;
    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done, borrow, zero;
    logic [15:0] s;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = 4'h0;
    logic [3:0]  b1 = 4'h0;
    logic        busy1, done1, borrow1, zero1;
    logic [3:0]  s1;

    int n_cmp  = 0;
    int n_fail = 0;

    sub_seq #(.NIB(4)) dut4 (
        .ck(ck), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .s(s), .borrow(borrow), .zero(zero)
    );

    sub_seq #(.NIB(1)) dut1 (
        .ck(ck), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .s(s1), .borrow(borrow1), .zero(zero1)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] es;
        logic        eb;
        logic        ez;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle4();
        int t;
        t = 0;
        while (busy === 1'b1 && t < 20) begin
            @(posedge ck); #1;
            t++;
        end
        if (t >= 20) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Launch one op on the NIB=4 instance and check timing and results; inject pokes start mid-RUN
    task automatic run_op(input string nm, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] es, input logic eb, input logic ez, input bit inject);
        int busy_n, done_n, done_at;
        logic [15:0] s_d;
        logic        b_d, z_d;
        logic        ez_eff;
        busy_n = 0; done_n = 0; done_at = -1;
        s_d = 16'h0000; b_d = 1'b0; z_d = 1'b0;
`ifdef SUB_SEQ_ZERO_FLAG_EN
        ez_eff = ez;
`else
        ez_eff = 1'b0;
`endif
        wait_idle4();
        start = 1'b1; a = va; b = vb;
        @(posedge ck); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (inject && i == 1) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0001;
            end
            if (inject && i == 2) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = i; s_d = s; b_d = borrow; z_d = zero;
                end
            end
            @(posedge ck); #1;
        end
        chk({nm, "_done_latency"}, 32'(done_at), 32'd4);
        chk({nm, "_done_count"}, 32'(done_n), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd5);
        chk({nm, "_s"}, {16'h0000, s_d}, {16'h0000, es});
        chk({nm, "_borrow"}, {31'd0, b_d}, {31'd0, eb});
        chk({nm, "_zero"}, {31'd0, z_d}, {31'd0, ez_eff});
        chk({nm, "_s_held"}, {15'd0, borrow, s}, {15'd0, eb, es});
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b0};
        vecs[5] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h00F0, 16'h000F, 16'h00E1, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", {15'd0, borrow, s}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        repeat (2) @(posedge ck);
        @(negedge ck) rst = 1'b0;
        @(posedge ck); #1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].es, vecs[i].eb, vecs[i].ez, 1'b0);

        // start pulsed during the second RUN cycle must be ignored
        run_op("ignore_start", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b1);

        // Reset during the third RUN cycle aborts with no done
        wait_idle4();
        start = 1'b1; a = 16'h1111; b = 16'h0000;
        @(posedge ck); #1;
        start = 1'b0;
        @(posedge ck); #1;
        @(posedge ck); #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_done", {31'd0, done}, 32'd0);
        chk("midrun_rst_out", {15'd0, borrow, s}, 32'd0);
        chk("midrun_rst_zero", {31'd0, zero}, 32'd0);
        @(negedge ck) rst = 1'b0;
        begin
            int dn;
            dn = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge ck); #1;
                if (done) dn++;
            end
            chk("midrun_rst_no_done", 32'(dn), 32'd0);
        end
        run_op("after_rst", 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0);

        // NIB=1 exhaustive with start held high
        start1 = 1'b1;
        for (int p = 0; p < 256; p++) begin
            int t;
            logic [7:0] pv;
            logic [4:0] exp5;
            pv = 8'(p);
            t = 0;
            while (busy1 === 1'b1 && t < 10) begin
                @(posedge ck); #1; t++;
            end
            a1 = pv[7:4]; b1 = pv[3:0];
            exp5 = {1'b0, pv[7:4]} - {1'b0, pv[3:0]};
            t = 0;
            do begin
                @(posedge ck); #1; t++;
            end while (done1 !== 1'b1 && t < 10);
            if (t >= 10) chk($sformatf("nib1_timeout_%0d", p), 32'd1, 32'd0);
            else chk($sformatf("nib1_%0h_%0h", pv[7:4], pv[3:0]), {27'd0, borrow1, s1}, {27'd0, exp5});
        end
        start1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
